// File: rtl/aes_avl_pkg.sv
// Shared register map and FSM state type for the Avalon AES front end.
package aes_avl_pkg;

  localparam logic [3:0] ADDR_KEY0  = 4'd0;
  localparam logic [3:0] ADDR_MSG0  = 4'd4;
  localparam logic [3:0] ADDR_DEC0  = 4'd8;
  localparam logic [3:0] ADDR_START = 4'd14;
  localparam logic [3:0] ADDR_DONE  = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_CAPT,
    ST_DONE
  } aes_state_e;

endpackage

// File: rtl/avalon_aes_interface.sv
// Avalon-MM register file and start/done sequencer feeding the AES
// decryption core; captures the plaintext into read-only registers.
import aes_avl_pkg::*;

module avalon_aes_interface (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         AVL_CS,
  input  logic         AVL_READ,
  input  logic         AVL_WRITE,
  input  logic [3:0]   AVL_ADDR,
  input  logic [3:0]   AVL_BYTE_EN,
  input  logic [31:0]  AVL_WRITEDATA,
  output logic [31:0]  AVL_READDATA,
  output logic [31:0]  EXPORT_DATA,
  output logic [127:0] AES_KEY,
  output logic [127:0] AES_MSG_ENC,
  output logic         AES_START,
  input  logic         AES_DONE,
  input  logic [127:0] AES_MSG_DEC
);

  aes_state_e  state;
  logic [31:0] rw_q  [16];
  logic [31:0] dec_q [4];
  logic        done_q;
  logic        busy;
  logic        wr_ok;
  logic        start_bit;
  logic [31:0] rd_mux;

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] din,
    input logic [3:0]  be
  );
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = din[8*i +: 8];
    return r;
  endfunction

  assign busy      = (state == ST_RUN) || (state == ST_CAPT);
  assign start_bit = rw_q[ADDR_START][0];

  // Key/ciphertext are frozen while the core is consuming them.
  always_comb begin
    wr_ok = 1'b0;
    if (AVL_CS && AVL_WRITE) begin
      unique case (1'b1)
        (AVL_ADDR < ADDR_DEC0): wr_ok = !busy;
        (AVL_ADDR >= 4'd12 && AVL_ADDR <= ADDR_START): wr_ok = 1'b1;
        default: wr_ok = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < 16; i++) rw_q[i] <= '0;
    end else if (wr_ok) begin
      rw_q[AVL_ADDR] <= merge(rw_q[AVL_ADDR], AVL_WRITEDATA, AVL_BYTE_EN);
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      (AVL_ADDR == ADDR_DONE): rd_mux = {31'd0, done_q};
      (AVL_ADDR[3:2] == 2'b10): rd_mux = dec_q[AVL_ADDR[1:0]];
      default: rd_mux = rw_q[AVL_ADDR];
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET)
      AVL_READDATA <= '0;
    else if (AVL_CS && AVL_READ)
      AVL_READDATA <= rd_mux;
    else
      AVL_READDATA <= '0;
  end

  // CAPT waits one cycle after AES_DONE for the core's output register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= ST_IDLE;
      AES_START <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < 4; i++) dec_q[i] <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          AES_START <= 1'b0;
          if (start_bit) begin
            state     <= ST_RUN;
            AES_START <= 1'b1;
          end
        end
        ST_RUN: begin
          AES_START <= 1'b1;
          if (AES_DONE) state <= ST_CAPT;
        end
        ST_CAPT: begin
          dec_q[0]  <= AES_MSG_DEC[127:96];
          dec_q[1]  <= AES_MSG_DEC[95:64];
          dec_q[2]  <= AES_MSG_DEC[63:32];
          dec_q[3]  <= AES_MSG_DEC[31:0];
          done_q    <= 1'b1;
          AES_START <= start_bit;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          if (!start_bit) begin
            done_q    <= 1'b0;
            AES_START <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            AES_START <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          AES_START <= 1'b0;
        end
      endcase
    end
  end

  assign AES_KEY = {rw_q[ADDR_KEY0], rw_q[ADDR_KEY0 + 4'd1],
                    rw_q[ADDR_KEY0 + 4'd2], rw_q[ADDR_KEY0 + 4'd3]};

  assign AES_MSG_ENC = {rw_q[ADDR_MSG0], rw_q[ADDR_MSG0 + 4'd1],
                        rw_q[ADDR_MSG0 + 4'd2], rw_q[ADDR_MSG0 + 4'd3]};

  assign EXPORT_DATA = {rw_q[ADDR_KEY0][31:16], rw_q[ADDR_KEY0 + 4'd3][15:0]};

endmodule

// File: tb/tb_avalon_aes_interface.sv
// Directed bench for avalon_aes_interface with a stub AES core whose
// plaintext output lags its done flag by one cycle.
module tb_avalon_aes_interface;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         AVL_CS, AVL_READ, AVL_WRITE;
  logic [3:0]   AVL_ADDR, AVL_BYTE_EN;
  logic [31:0]  AVL_WRITEDATA, AVL_READDATA, EXPORT_DATA;
  logic [127:0] AES_KEY, AES_MSG_ENC, AES_MSG_DEC;
  logic         AES_START, AES_DONE;

  localparam logic [127:0] KEY   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PLAIN = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] EARLY = 128'hdeadbeef0badf00d5555aaaa12345678;
  localparam int LAT = 10;

  int n_chk = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  avalon_aes_interface dut (
    .CLK(CLK), .RESET(RESET),
    .AVL_CS(AVL_CS), .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE),
    .AVL_ADDR(AVL_ADDR), .AVL_BYTE_EN(AVL_BYTE_EN),
    .AVL_WRITEDATA(AVL_WRITEDATA), .AVL_READDATA(AVL_READDATA),
    .EXPORT_DATA(EXPORT_DATA), .AES_KEY(AES_KEY),
    .AES_MSG_ENC(AES_MSG_ENC), .AES_START(AES_START),
    .AES_DONE(AES_DONE), .AES_MSG_DEC(AES_MSG_DEC)
  );

  // Stub core: done after LAT cycles of start, plaintext one cycle later.
  int stub_cnt;
  always @(posedge CLK) begin
    if (RESET || !AES_START) begin
      stub_cnt <= 0;
      AES_DONE <= 1'b0;
    end else if (stub_cnt != LAT) begin
      stub_cnt <= stub_cnt + 1;
    end else begin
      AES_DONE <= 1'b1;
    end
    AES_MSG_DEC <= AES_DONE ? PLAIN : EARLY;
  end

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic avl_write(input logic [3:0] a, input logic [31:0] d,
                           input logic [3:0] be);
    @(negedge CLK);
    AVL_CS = 1'b1; AVL_WRITE = 1'b1;
    AVL_ADDR = a; AVL_WRITEDATA = d; AVL_BYTE_EN = be;
    @(negedge CLK);
    AVL_CS = 1'b0; AVL_WRITE = 1'b0; AVL_BYTE_EN = 4'h0;
  endtask

  task automatic avl_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge CLK);
    AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = a;
    @(negedge CLK);
    d = AVL_READDATA;
    AVL_CS = 1'b0; AVL_READ = 1'b0;
  endtask

  task automatic load_key_ct();
    for (int i = 0; i < 4; i++) begin
      avl_write(4'(i), KEY[127-32*i -: 32], 4'hF);
      avl_write(4'(4+i), CT[127-32*i -: 32], 4'hF);
    end
  endtask

  task automatic poll_done(input string name);
    logic [31:0] d;
    d = '0;
    for (int i = 0; i < 200 && d != 32'd1; i++) avl_read(4'd15, d);
    check(name, 128'(d), 128'd1);
  endtask

  task automatic check_dec(input string name);
    logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      avl_read(4'(8+i), d);
      check($sformatf("%s_reg%0d", name, 8+i), 128'(d),
            128'(PLAIN[127-32*i -: 32]));
    end
  endtask

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [31:0] d;

    vecs[0] = '{4'd12, 32'hAABBCCDD, 4'b0101, 32'h00BB00DD};
    vecs[1] = '{4'd13, 32'hFFFFFFFF, 4'b1111, 32'hFFFFFFFF};
    vecs[2] = '{4'd13, 32'h12345678, 4'b1000, 32'h12FFFFFF};
    vecs[3] = '{4'd8,  32'h55555555, 4'b1111, 32'h00000000};
    vecs[4] = '{4'd15, 32'hFFFFFFFF, 4'b1111, 32'h00000000};
    vecs[5] = '{4'd1,  32'h04050607, 4'b1111, 32'h04050607};
    vecs[6] = '{4'd12, 32'h11111111, 4'b0000, 32'h00BB00DD};

    RESET = 1'b1;
    AVL_CS = 0; AVL_READ = 0; AVL_WRITE = 0;
    AVL_ADDR = 0; AVL_BYTE_EN = 0; AVL_WRITEDATA = 0;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;

    check("rst_start", 128'(AES_START), 128'd0);
    check("rst_export", 128'(EXPORT_DATA), 128'd0);
    check("rst_readdata", 128'(AVL_READDATA), 128'd0);
    for (int i = 0; i < 16; i++) begin
      avl_read(4'(i), d);
      check($sformatf("rst_reg%0d", i), 128'(d), 128'd0);
    end

    for (int i = 0; i < 7; i++) begin
      avl_write(vecs[i].addr, vecs[i].wdata, vecs[i].be);
      avl_read(vecs[i].addr, d);
      check($sformatf("vec%0d", i), 128'(d), 128'(vecs[i].exp));
    end
    @(negedge CLK);
    check("rd_idle_zero", 128'(AVL_READDATA), 128'd0);

    // Simultaneous read and write returns the old value.
    @(negedge CLK);
    AVL_CS = 1; AVL_READ = 1; AVL_WRITE = 1;
    AVL_ADDR = 4'd13; AVL_WRITEDATA = 32'hCAFEF00D; AVL_BYTE_EN = 4'hF;
    @(negedge CLK);
    d = AVL_READDATA;
    AVL_CS = 0; AVL_READ = 0; AVL_WRITE = 0; AVL_BYTE_EN = 0;
    check("rw_old", 128'(d), 128'h12FFFFFF);
    avl_read(4'd13, d);
    check("rw_new", 128'(d), 128'hCAFEF00D);

    load_key_ct();
    check("key_out", AES_KEY, KEY);
    check("msg_out", AES_MSG_ENC, CT);
    check("export", 128'(EXPORT_DATA), 128'h00010e0f);

    avl_write(4'd14, 32'd1, 4'hF);
    check("start_lat0", 128'(AES_START), 128'd0);
    @(negedge CLK);
    check("start_lat1", 128'(AES_START), 128'd1);
    avl_write(4'd0, 32'hFFFFFFFF, 4'hF);
    check("key_frozen", 128'(AES_KEY[127:96]), 128'h00010203);
    poll_done("done1");
    check_dec("dec1");
    check("key_after", AES_KEY, KEY);

    avl_write(4'd14, 32'd0, 4'hF);
    check("stop_lat0", 128'(AES_START), 128'd1);
    @(negedge CLK);
    check("stop_lat1", 128'(AES_START), 128'd0);
    avl_read(4'd15, d);
    check("done_clr", 128'(d), 128'd0);

    // Reset while RUN, after regs 8-11 already hold a result.
    avl_write(4'd14, 32'd1, 4'hF);
    repeat (3) @(negedge CLK);
    check("run_start", 128'(AES_START), 128'd1);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    check("mid_rst_start", 128'(AES_START), 128'd0);
    check("mid_rst_export", 128'(EXPORT_DATA), 128'd0);
    for (int i = 8; i < 16; i++) begin
      if (i == 12) i = 15;
      avl_read(4'(i), d);
      check($sformatf("mid_rst_reg%0d", i), 128'(d), 128'd0);
    end
    repeat (LAT + 4) @(negedge CLK);
    check("no_restart", 128'(AES_START), 128'd0);

    load_key_ct();
    avl_write(4'd14, 32'd1, 4'hF);
    poll_done("done2");
    check_dec("dec2");
    avl_write(4'd14, 32'd0, 4'hF);
    @(negedge CLK);
    check("stop2", 128'(AES_START), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/avalon_aes_interface.md
# avalon_aes_interface

Avalon-MM slave that sits directly upstream of the AES decryption core and feeds it. It holds the key and ciphertext in a 16 × 32-bit register file and drives the core's key, message and start inputs. It sequences the start/done handshake and captures the decrypted message into read-only registers for the CPU.

## Interface
- No parameters; widths are fixed by the register map.
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- AVL_CS  in  1  slave chip select; all Avalon access is ignored when low
- AVL_READ  in  1  read strobe
- AVL_WRITE  in  1  write strobe
- AVL_ADDR  in  4  word address
- AVL_BYTE_EN  in  4  byte-lane write enables
- AVL_WRITEDATA  in  32  write data
- AVL_READDATA  out  32  registered read data
- EXPORT_DATA  out  32  {reg0[31:16], reg3[15:0]} for hex display
- AES_KEY  out  128  {reg0, reg1, reg2, reg3}; reg0 drives bits 127:96
- AES_MSG_ENC  out  128  {reg4, reg5, reg6, reg7}
- AES_START  out  1  start request to the core
- AES_DONE  in  1  completion flag from the core
- AES_MSG_DEC  in  128  decrypted message from the core

## Operation
- Register map:
  - 0–3: key.
  - 4–7: ciphertext.
  - 8–11: decrypted text, read-only, {8,9,10,11} = bits 127:0 MSB-first.
  - 12–13: scratch.
  - 14: START, bit 0.
  - 15: DONE, bit 0, read-only; other bits read 0.
- Writes (AVL_CS & AVL_WRITE) are per byte lane under AVL_BYTE_EN.
  - Writes to 8–11 and 15 are dropped.
  - Writes to 0–7 are dropped while the FSM is in RUN or CAPT, so key and ciphertext stay frozen during a decrypt.
  - Writes to 12–14 are accepted in every state.
- FSM states are IDLE, RUN, CAPT and DONE.
  - IDLE: AES_START = 0. If START bit 0 = 1, go to RUN.
  - RUN: AES_START = 1. On AES_DONE = 1, go to CAPT.
  - CAPT: AES_START = 1. This state exists because the core's output register lags AES_DONE by one cycle. Load regs 8–11 from AES_MSG_DEC, set reg15[0] = 1, go to DONE.
  - DONE: AES_START = reg14[0]. If reg14[0] = 0, clear reg15[0] and go to IDLE.
- Keeping AES_START high through DONE holds the core in its finished-wait state. Dropping it releases the core to its end state, from which the next start restarts it.
- Clearing START during RUN or CAPT does not abort the decrypt. The block completes the capture, and DONE exits on its first cycle.
- Setting START again while in DONE keeps the FSM in DONE. A new decrypt requires the START bit to go 1 → 0 → 1.

## Timing
- Reset values:
  - All 16 registers = 0.
  - FSM = IDLE.
  - AES_START = 0.
  - AVL_READDATA = 0.
  - EXPORT_DATA = 0.
- Read latency is 1 cycle.
  - AVL_READDATA is valid on the cycle after AVL_CS & AVL_READ are sampled.
  - When no read was sampled, AVL_READDATA = 0.
  - Read data reflects the register contents before the edge on which the read is sampled; a write or capture on that same edge is not visible.
- A write of START = 1 at edge N produces AES_START = 1 after edge N+1; the FSM enters RUN on edge N+1.
- AES_DONE first sampled high at edge M:
  - CAPT is entered at M.
  - Regs 8–11 and DONE are updated at M+1.
  - A read of reg15 issued after edge M+1 returns 1.
- A write of START = 0 at edge K, while in DONE, gives AES_START = 0 and state IDLE after edge K+1.
- RESET mid-operation returns every output to its reset value on the next edge and discards any capture in progress.
- A simultaneous read and write in the same cycle are both performed; the read returns the old value.

## Structure
- Package aes_avl_pkg holds:
  - Register address localparams: ADDR_KEY0 = 0, ADDR_MSG0 = 4, ADDR_DEC0 = 8, ADDR_START = 14, ADDR_DONE = 15.
  - The FSM state enum.
- A single module with no sub-modules. The byte-lane merge is an inline function.
- The AES core is instantiated by the top level, not inside this block.

## Test plan
- Reset, then read all 16 addresses → every AVL_READDATA = 0, AES_START = 0, EXPORT_DATA = 0.
- Write 0xAABBCCDD to reg 12 with AVL_BYTE_EN = 4'b0101, then read reg 12 → 0x00BB00DD.
- Full decrypt through the real AES core:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f; ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a; START = 1; poll reg15.
  - Required: reg15 reads 1; regs 8–11 read 00112233, 44556677, 8899aabb, ccddeeff.
  - Then write START = 0 → AES_START drops one cycle later and reg15 reads 0.
- During RUN, write 0xFFFFFFFF to reg 0 → the write is dropped, AES_KEY[127:96] stays 0x00010203, and the decrypt result is unchanged.
- Stub core that raises AES_DONE and changes AES_MSG_DEC one cycle later → regs 8–11 hold the later value, not the value present on the AES_DONE cycle.
- Assert RESET while in RUN → AES_START = 0, regs 8–11 and 15 = 0, and a new START = 1 begins a fresh decrypt.
